// File: rtl/hello_seq.sv
`default_nettype none
// ============================================================================
// Module   : hello_seq
// Purpose  : Streams the contents of a sequential ROM to a ready/valid sink,
//            REPS times per start request, with GAP idle cycles between
//            passes. Each pass rewinds the ROM, then fetches one byte at a
//            time until the ROM reports empty.
// Ports    : clock      - system clock, rising edge
//            reset      - synchronous, active-high reset
//            start      - begin a sequence (sampled only while idle)
//            abort      - terminate the current sequence
//            rom_reset  - rewind strobe to the ROM (combinational)
//            rom_get    - fetch strobe to the ROM (combinational)
//            rom_data   - ROM registered output, valid the cycle after rom_get
//            rom_empty  - ROM exhausted flag
//            data       - byte presented to the sink (registered)
//            valid      - data holds a byte for the sink (registered)
//            ready      - sink accepts data when valid and ready are high
//            busy       - high whenever a sequence is in progress
//            done       - one-cycle pulse on normal completion (registered)
// Revision : 1.0 - initial release
// ============================================================================
module hello_seq #(
    parameter int W    = 8,
    parameter int REPS = 1,
    parameter int GAP  = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    output logic         rom_reset,
    output logic         rom_get,
    input  logic [W-1:0] rom_data,
    input  logic         rom_empty,
    output logic [W-1:0] data,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         done
);

    localparam logic [7:0] REPS_C = 8'(REPS);
    localparam logic [7:0] GAP_C  = 8'(GAP);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REWIND = 3'd1,
        FETCH  = 3'd2,
        LOAD   = 3'd3,
        SEND   = 3'd4,
        WAIT   = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] pass_cnt;
    logic [7:0] gap_cnt;

    // A system reset must also rewind the ROM so both sides start aligned.
    assign rom_reset = reset | (state == REWIND);
    // FETCH is only ever entered with valid low, so this cannot overlap a
    // pending byte.
    assign rom_get   = (state == FETCH) & ~rom_empty;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= 1'b0;
            done     <= 1'b0;
            data     <= '0;
            pass_cnt <= 8'd0;
            gap_cnt  <= 8'd0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                // Any handshake in this same cycle has already completed on
                // the wire; the byte counts as delivered and we just stop.
                state <= IDLE;
                valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // abort outranks start even when idle
                        if (start && !abort) begin
                            state    <= REWIND;
                            pass_cnt <= REPS_C;
                        end
                    end
                    REWIND: begin
                        state <= FETCH;
                    end
                    FETCH: begin
                        if (!rom_empty) begin
                            state <= LOAD;
                        end else begin
                            // Saturating decrement: a zero count never wraps.
                            pass_cnt <= (pass_cnt != 8'd0) ? (pass_cnt - 8'd1) : 8'd0;
                            if (pass_cnt > 8'd1) begin
                                if (GAP_C != 8'd0) begin
                                    state   <= WAIT;
                                    gap_cnt <= GAP_C;
                                end else begin
                                    state <= REWIND;
                                end
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        data  <= rom_data;
                        valid <= 1'b1;
                        state <= SEND;
                    end
                    SEND: begin
                        if (ready) begin
                            valid <= 1'b0;
                            state <= FETCH;
                        end
                    end
                    WAIT: begin
                        // gap_cnt holds the WAIT cycles still to spend,
                        // including the current one.
                        if (gap_cnt <= 8'd1) begin
                            state <= REWIND;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
